control_unit: RTL and testbench

Instruction register, microstep sequencer and control decoder for the 8-bit bus computer. It sits between the shared bus and every other unit: program counter, MAR/RAM, A/B/ALU, flags and output register. It latches the fetched instruction from the bus and drives its operand nibble back onto the bus. It sequences five microsteps per instruction and emits one active-high control line per datapath enable.

---
 rtl/control_pkg.sv | 47 ++++
 rtl/control_unit_microcode_rom.sv | 91 +++++++++
 rtl/control_unit.sv | 111 +++++++++++
 tb/tb_control_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the bus-computer control unit.
// Contents: opcode encodings, microstep encodings, control-word bit positions
// and the packed control-word type used between the microcode ROM and the top.
package control_pkg;

    // Opcodes live in the high nibble of the instruction register.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Microsteps.
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Control-word bit positions, one per datapath enable.
    localparam int CTRL_W   = 16;
    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

endpackage

// File: rtl/control_unit_microcode_rom.sv
// Combinational microcode table.
// Ports:
//   opcode      - instruction high nibble
//   step        - current microstep T0..T4
//   carry_flag  - registered carry, qualifies JC in T2
//   zero_flag   - registered zero, qualifies JZ in T2
//   ctrl        - control word for this opcode/step
module microcode_rom
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] step,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (step)
            T0: begin
                ctrl[CTRL_CO] = 1'b1;
                ctrl[CTRL_MI] = 1'b1;
            end
            T1: begin
                ctrl[CTRL_RO] = 1'b1;
                ctrl[CTRL_II] = 1'b1;
                ctrl[CTRL_CE] = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[CTRL_IO] = 1'b1;
                        ctrl[CTRL_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl[CTRL_IO] = 1'b1;
                        ctrl[CTRL_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl[CTRL_IO] = 1'b1;
                        ctrl[CTRL_J]  = 1'b1;
                    end
                    OP_JC: begin
                        ctrl[CTRL_IO] = carry_flag;
                        ctrl[CTRL_J]  = carry_flag;
                    end
                    OP_JZ: begin
                        ctrl[CTRL_IO] = zero_flag;
                        ctrl[CTRL_J]  = zero_flag;
                    end
                    OP_OUT: begin
                        ctrl[CTRL_AO] = 1'b1;
                        ctrl[CTRL_OI] = 1'b1;
                    end
                    OP_HLT: begin
                        ctrl[CTRL_HLT] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl[CTRL_RO] = 1'b1;
                        ctrl[CTRL_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[CTRL_RO] = 1'b1;
                        ctrl[CTRL_BI] = 1'b1;
                    end
                    OP_STA: begin
                        ctrl[CTRL_AO] = 1'b1;
                        ctrl[CTRL_RI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl[CTRL_EO] = 1'b1;
                    ctrl[CTRL_AI] = 1'b1;
                    ctrl[CTRL_FI] = 1'b1;
                    ctrl[CTRL_SU] = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction register, microstep sequencer and control decoder.
// Ports:
//   clock, reset_n         - rising-edge clock, async active-low reset
//   bus                    - shared tri-state bus (IR load source, operand drive)
//   carry_flag, zero_flag  - registered ALU flags for conditional jumps
//   HLT..FI                - one active-high control line per datapath enable
//   step, opcode           - debug views of the sequencer and IR[7:4]
module control_unit
    import control_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned STEPS  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    inout  wire [DATA_W-1:0]  bus,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic              HLT,
    output logic              MI,
    output logic              RI,
    output logic              RO,
    output logic              IO,
    output logic              II,
    output logic              AI,
    output logic              AO,
    output logic              EO,
    output logic              SU,
    output logic              BI,
    output logic              OI,
    output logic              CE,
    output logic              CO,
    output logic              J,
    output logic              FI,
    output logic [2:0]        step,
    output logic [3:0]        opcode
);

    localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);

    logic [DATA_W-1:0] ir_q;
    logic [2:0]        step_q;
    logic              halted_q;
    ctrl_word_t        rom_ctrl;
    ctrl_word_t        ctrl;

    microcode_rom u_rom (
        .opcode     (ir_q[DATA_W-1 -: 4]),
        .step       (step_q),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (rom_ctrl)
    );

    // Reset forces every line low without waiting for an edge; once halted
    // only HLT stays up so nothing else in the datapath moves.
    always_comb begin
        ctrl = '0;
        if (!reset_n) begin
            ctrl = '0;
        end else if (halted_q) begin
            ctrl[CTRL_HLT] = 1'b1;
        end else begin
            ctrl = rom_ctrl;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir_q     <= '0;
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (ctrl[CTRL_II]) begin
                ir_q <= bus;
            end
            // Halting freezes the step counter on the HLT step itself.
            if (ctrl[CTRL_HLT]) begin
                halted_q <= 1'b1;
            end else if (step_q == STEP_LAST) begin
                step_q <= T0;
            end else begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    assign bus = ctrl[CTRL_IO] ? {{(DATA_W - ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]}
                               : {DATA_W{1'bz}};

    assign HLT    = ctrl[CTRL_HLT];
    assign MI     = ctrl[CTRL_MI];
    assign RI     = ctrl[CTRL_RI];
    assign RO     = ctrl[CTRL_RO];
    assign IO     = ctrl[CTRL_IO];
    assign II     = ctrl[CTRL_II];
    assign AI     = ctrl[CTRL_AI];
    assign AO     = ctrl[CTRL_AO];
    assign EO     = ctrl[CTRL_EO];
    assign SU     = ctrl[CTRL_SU];
    assign BI     = ctrl[CTRL_BI];
    assign OI     = ctrl[CTRL_OI];
    assign CE     = ctrl[CTRL_CE];
    assign CO     = ctrl[CTRL_CO];
    assign J      = ctrl[CTRL_J];
    assign FI     = ctrl[CTRL_FI];
    assign step   = step_q;
    assign opcode = ir_q[DATA_W-1 -: 4];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a table of per-cycle vectors is
// driven, each vector's expectation queued, and popped for comparison
// on the following falling edge; hand sequences cover halt and async reset.
module tb_control_unit;

    // Bench-local control vector layout.
    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    typedef struct {
        logic        bus_en;
        logic [7:0]  bus_val;
        logic        carry;
        logic        zero;
        logic [2:0]  exp_step;
        logic [3:0]  exp_op;
        logic [15:0] exp_ctrl;
        logic        chk_bus;
        logic [7:0]  exp_bus;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       carry_flag;
    logic       zero_flag;
    logic       tb_bus_en;
    logic [7:0] tb_bus_val;
    wire  [7:0] bus;
    logic HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI;
    logic [2:0] step;
    logic [3:0] opcode;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    vec_t exp_q[$];
    logic [3:0] last_op;

    assign bus = tb_bus_en ? tb_bus_val : 8'hzz;

    always #5 clock = ~clock;

    control_unit #(
        .DATA_W (8),
        .ADDR_W (4),
        .STEPS  (5)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .HLT        (HLT),
        .MI         (MI),
        .RI         (RI),
        .RO         (RO),
        .IO         (IO),
        .II         (II),
        .AI         (AI),
        .AO         (AO),
        .EO         (EO),
        .SU         (SU),
        .BI         (BI),
        .OI         (OI),
        .CE         (CE),
        .CO         (CO),
        .J          (J),
        .FI         (FI),
        .step       (step),
        .opcode     (opcode)
    );

    function automatic logic [15:0] got_ctrl();
        return {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic be, input logic [7:0] bv, input logic c, input logic z,
                       input logic [2:0] st, input logic [3:0] op, input logic [15:0] ctl,
                       input logic cb, input logic [7:0] eb);
        vec_t v;
        v.bus_en = be; v.bus_val = bv; v.carry = c; v.zero = z;
        v.exp_step = st; v.exp_op = op; v.exp_ctrl = ctl; v.chk_bus = cb; v.exp_bus = eb;
        vecs.push_back(v);
    endtask

    // Fetch plus three execute steps with hand-written expectations.
    task automatic instr(input logic [7:0] b, input logic c, input logic z,
                         input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                         input logic cb2, input logic [7:0] eb2);
        add(1'b0, 8'h00, c, z, 3'd0, last_op, C_CO | C_MI, 1'b0, 8'h00);
        add(1'b1, b,     c, z, 3'd1, last_op, C_RO | C_II | C_CE, 1'b0, 8'h00);
        add(1'b0, 8'h00, c, z, 3'd2, b[7:4], e2, cb2, eb2);
        add(1'b0, 8'h00, c, z, 3'd3, b[7:4], e3, 1'b0, 8'h00);
        add(1'b0, 8'h00, c, z, 3'd4, b[7:4], e4, 1'b0, 8'h00);
        last_op = b[7:4];
    endtask

    // Called just after a rising edge: drive, queue expectation, compare on
    // the falling edge, then advance to just after the next rising edge.
    task automatic run_vec(input vec_t v);
        vec_t e;
        tb_bus_en  = v.bus_en;
        tb_bus_val = v.bus_val;
        carry_flag = v.carry;
        zero_flag  = v.zero;
        exp_q.push_back(v);
        @(negedge clock);
        e = exp_q.pop_front();
        check("step", {13'd0, step}, {13'd0, e.exp_step});
        check("opcode", {12'd0, opcode}, {12'd0, e.exp_op});
        check("ctrl", got_ctrl(), e.exp_ctrl);
        if (e.chk_bus) check("bus", {8'd0, bus}, {8'd0, e.exp_bus});
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        reset_n    = 1'b0;
        carry_flag = 1'b0;
        zero_flag  = 1'b0;
        tb_bus_en  = 1'b1;
        tb_bus_val = 8'hFF;
        last_op    = 4'h0;

        // Program table.
        instr(8'h1E, 1'b0, 1'b0, C_IO | C_MI, C_RO | C_AI, 16'h0, 1'b1, 8'h0E);        // LDA
        instr(8'h3F, 1'b0, 1'b0, C_IO | C_MI, C_RO | C_BI,
              C_EO | C_AI | C_SU | C_FI, 1'b1, 8'h0F);                                // SUB
        instr(8'h27, 1'b0, 1'b0, C_IO | C_MI, C_RO | C_BI, C_EO | C_AI | C_FI, 1'b1, 8'h07);
        instr(8'h4C, 1'b0, 1'b0, C_IO | C_MI, C_AO | C_RI, 16'h0, 1'b1, 8'h0C);        // STA
        instr(8'h5A, 1'b0, 1'b0, C_IO | C_AI, 16'h0, 16'h0, 1'b1, 8'h0A);              // LDI
        instr(8'h63, 1'b0, 1'b0, C_IO | C_J, 16'h0, 16'h0, 1'b1, 8'h03);               // JMP
        instr(8'h75, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);                    // JC, C=0
        instr(8'h75, 1'b1, 1'b0, C_IO | C_J, 16'h0, 16'h0, 1'b1, 8'h05);               // JC, C=1
        instr(8'h85, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);                    // JZ, Z=0
        instr(8'h85, 1'b0, 1'b1, C_IO | C_J, 16'h0, 16'h0, 1'b1, 8'h05);               // JZ, Z=1
        instr(8'hE0, 1'b0, 1'b0, C_AO | C_OI, 16'h0, 16'h0, 1'b0, 8'h00);              // OUT
        instr(8'h9F, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);                    // unused op
        instr(8'h00, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);                    // NOP
        // HLT: fetch, T2, then frozen.
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, last_op, C_CO | C_MI, 1'b0, 8'h00);
        add(1'b1, 8'hF0, 1'b0, 1'b0, 3'd1, last_op, C_RO | C_II | C_CE, 1'b0, 8'h00);
        for (int i = 0; i < 13; i++) begin
            add(1'b0, 8'h00, i[0], i[1], 3'd2, 4'hF, C_HLT, 1'b0, 8'h00);
        end

        // Reset held for three cycles with the bus driven to all ones.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_step", {13'd0, step}, 16'd0);
        check("rst_opcode", {12'd0, opcode}, 16'd0);
        check("rst_ctrl", got_ctrl(), 16'h0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        tb_bus_en = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset pulse releases the halt.
        reset_n = 1'b0;
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'h0, 16'h0, 1'b0, 8'h00);
        run_vec(vecs[vecs.size() - 1]);
        reset_n = 1'b1;
        last_op = 4'h0;
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'h0, C_CO | C_MI, 1'b0, 8'h00);
        run_vec(vecs[vecs.size() - 1]);

        // ADD, then async reset in the middle of T3.
        add(1'b1, 8'h2B, 1'b0, 1'b0, 3'd1, 4'h0, C_RO | C_II | C_CE, 1'b0, 8'h00);
        run_vec(vecs[vecs.size() - 1]);
        add(1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 4'h2, C_IO | C_MI, 1'b1, 8'h0B);
        run_vec(vecs[vecs.size() - 1]);
        tb_bus_en = 1'b0;
        #1;
        check("t3_ctrl", got_ctrl(), C_RO | C_BI);
        check("t3_step", {13'd0, step}, 16'd3);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_ctrl", got_ctrl(), 16'h0);
        check("abort_step", {13'd0, step}, 16'd0);
        check("abort_opcode", {12'd0, opcode}, 16'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        v.bus_en = 1'b0; v.bus_val = 8'h00; v.carry = 1'b0; v.zero = 1'b0;
        v.exp_step = 3'd0; v.exp_op = 4'h0; v.exp_ctrl = C_CO | C_MI;
        v.chk_bus = 1'b0; v.exp_bus = 8'h00;
        run_vec(v);
        v.bus_en = 1'b1; v.bus_val = 8'h13; v.exp_step = 3'd1;
        v.exp_ctrl = C_RO | C_II | C_CE;
        run_vec(v);
        v.bus_en = 1'b0; v.exp_step = 3'd2; v.exp_op = 4'h1;
        v.exp_ctrl = C_IO | C_MI; v.chk_bus = 1'b1; v.exp_bus = 8'h03;
        run_vec(v);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
